pipe_stage_reg: RTL and testbench

- Generic, parametrised inter-stage pipeline register; the successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one packed payload (control + data fields concatenated by the instantiating stage) with a valid/ready handshake.
- Supports a global stall (memory busywait), a flush (branch/jump squash) and an optional skid entry so that in_ready can be registered.
- Exposes occupancy and saturating stall/flush counters for performance debug.

---
 rtl/cpu_pipe_pkg.sv | 35 +++
 rtl/pipe_stage_reg_sat_counter.sv | 30 +++
 rtl/pipe_stage_reg.sv | 131 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline payload widths, EX/MEM field offsets and stage-register occupancy states.
package cpu_pipe_pkg;

    localparam int IF_ID_W  = 64;
    localparam int ID_EX_W  = 150;
    localparam int EX_MEM_W = 108;
    localparam int MEM_WB_W = 104;

    // EX/MEM payload layout, LSB first: field offsets and widths.
    localparam int EXM_WB_SEL_LSB     = 0;
    localparam int EXM_WB_SEL_W       = 2;
    localparam int EXM_MEM_READ_LSB   = 2;
    localparam int EXM_MEM_READ_W     = 3;
    localparam int EXM_MEM_WRITE_LSB  = 5;
    localparam int EXM_MEM_WRITE_W    = 1;
    localparam int EXM_READ_DATA2_LSB = 6;
    localparam int EXM_READ_DATA2_W   = 32;
    localparam int EXM_ALU_RESULT_LSB = 38;
    localparam int EXM_ALU_RESULT_W   = 32;
    localparam int EXM_PC_LSB         = 70;
    localparam int EXM_PC_W           = 32;
    localparam int EXM_DEST_ADDR_LSB  = 102;
    localparam int EXM_DEST_ADDR_W    = 5;
    localparam int EXM_REG_WRITE_LSB  = 107;
    localparam int EXM_REG_WRITE_W    = 1;

    // Encoded as {main_valid, skid_valid}.
    typedef enum logic [1:0] {
        ST_EMPTY     = 2'b00,
        ST_SKID_ONLY = 2'b01,
        ST_ONE       = 2'b10,
        ST_FULL      = 2'b11
    } stage_st_e;

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter for performance debug; holds at all-ones, never wraps.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) count_q <= '0;
        else      count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with stall/flush and optional skid entry; 1-cycle latency.
// SKID=1 registers in_ready (deasserts only when the skid entry is occupied); stall freezes everything.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int DATA_W         = EX_MEM_W,
    parameter int SKID           = 1,
    parameter int CLEAR_ON_FLUSH = 1,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic              in_fire, out_fire;
    stage_st_e         cur_st;

    assign cur_st = stage_st_e'({main_valid_q, skid_valid_q});

    always_comb begin
        if (SKID != 0) in_ready = !skid_valid_q && !stall;
        else           in_ready = !stall && (!main_valid_q || out_ready);
    end

    assign in_fire  = in_valid && in_ready && !stall;
    assign out_fire = main_valid_q && out_ready && !stall;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_data_d  = main_data_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
            if (CLEAR_ON_FLUSH != 0) begin
                main_data_d = '0;
                skid_data_d = '0;
            end
        end else if (!stall) begin
            if (SKID != 0) begin
                case (cur_st)
                    ST_EMPTY: begin
                        if (in_fire) begin
                            main_data_d  = in_data;
                            main_valid_d = 1'b1;
                        end
                    end
                    ST_ONE: begin
                        if (in_fire && out_fire) begin
                            main_data_d = in_data;
                        end else if (in_fire) begin
                            skid_data_d  = in_data;
                            skid_valid_d = 1'b1;
                        end else if (out_fire) begin
                            main_valid_d = 1'b0;
                        end
                    end
                    ST_FULL: begin
                        if (out_fire) begin
                            main_data_d  = skid_data_q;
                            skid_valid_d = 1'b0;
                        end
                    end
                    default: begin
                        main_valid_d = 1'b0;
                        skid_valid_d = 1'b0;
                    end
                endcase
            end else begin
                if (in_fire) begin
                    main_data_d  = in_data;
                    main_valid_d = 1'b1;
                end else if (out_fire) begin
                    main_valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    // A stall cycle that is also a flush is counted only as a flush.
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall && !flush),
        .clear (1'b0),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush && (main_valid_q || skid_valid_q)),
        .clear (1'b0),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: SKID=1 main instance, CNT_W=2 twin sharing its inputs, and a separate SKID=0 instance.
module tb_pipe_stage_reg;

    localparam int DW = 108;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall, flush, in_valid, out_ready;
    logic [DW-1:0] in_data;
    logic          in_ready, out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [15:0]   stall_cnt, flush_cnt;

    logic          sat_in_ready, sat_out_valid;
    logic [DW-1:0] sat_out_data;
    logic [1:0]    sat_occupancy;
    logic [1:0]    sat_stall_cnt, sat_flush_cnt;

    logic          s0_stall, s0_flush, s0_in_valid, s0_out_ready;
    logic [DW-1:0] s0_in_data;
    logic          s0_in_ready, s0_out_valid;
    logic [DW-1:0] s0_out_data;
    logic [1:0]    s0_occupancy;
    logic [15:0]   s0_stall_cnt, s0_flush_cnt;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(1), .CLEAR_ON_FLUSH(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_ready(sat_in_ready), .in_data(in_data),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_data(sat_out_data),
        .occupancy(sat_occupancy), .stall_cnt(sat_stall_cnt), .flush_cnt(sat_flush_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .SKID(0), .CLEAR_ON_FLUSH(1), .CNT_W(16)) u_s0 (
        .clk(clk), .rst(rst), .stall(s0_stall), .flush(s0_flush),
        .in_valid(s0_in_valid), .in_ready(s0_in_ready), .in_data(s0_in_data),
        .out_valid(s0_out_valid), .out_ready(s0_out_ready), .out_data(s0_out_data),
        .occupancy(s0_occupancy), .stall_cnt(s0_stall_cnt), .flush_cnt(s0_flush_cnt)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        s0_stall = 1'b0; s0_flush = 1'b0; s0_in_valid = 1'b0; s0_out_ready = 1'b0; s0_in_data = '0;
        tick(); tick();
        rst = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_s0_in_ready", s0_in_ready, 1);
        tick();
        chk("idle_occupancy", occupancy, 0);

        // Streaming
        out_ready = 1'b1; in_valid = 1'b1; in_data = 108'h1;
        chk("str_in_ready_1", in_ready, 1);
        tick();
        chk("str_out_1", out_data, 108'h1);
        chk("str_valid_1", out_valid, 1);
        chk("str_occ_1", occupancy, 1);
        in_data = 108'h2;
        chk("str_in_ready_2", in_ready, 1);
        tick();
        chk("str_out_2", out_data, 108'h2);
        chk("str_occ_2", occupancy, 1);
        in_data = 108'h3;
        chk("str_in_ready_3", in_ready, 1);
        tick();
        chk("str_out_3", out_data, 108'h3);
        chk("str_occ_3", occupancy, 1);
        in_valid = 1'b0;
        tick();
        chk("str_drain_valid", out_valid, 0);
        chk("str_drain_occ", occupancy, 0);

        // Backpressure into the skid entry
        out_ready = 1'b0; in_valid = 1'b1; in_data = 108'hA;
        tick();
        chk("bp_occ_A", occupancy, 1);
        in_data = 108'hB;
        chk("bp_in_ready_B", in_ready, 1);
        tick();
        chk("bp_occ_full", occupancy, 2);
        chk("bp_in_ready_full", in_ready, 0);
        in_data = 108'hC;
        tick();
        chk("bp_occ_held", occupancy, 2);
        chk("bp_out_A_held", out_data, 108'hA);
        out_ready = 1'b1;
        chk("bp_in_ready_still0", in_ready, 0);
        tick();
        chk("bp_out_B", out_data, 108'hB);
        chk("bp_occ_after_full", occupancy, 1);
        chk("bp_in_ready_reopen", in_ready, 1);
        tick();
        chk("bp_out_C", out_data, 108'hC);
        chk("bp_occ_C", occupancy, 1);
        in_valid = 1'b0;
        tick();
        chk("bp_drain_occ", occupancy, 0);

        // Stall holds everything; CNT_W=2 twin saturates
        out_ready = 1'b0; in_valid = 1'b1; in_data = 108'h5;
        tick();
        chk("st_loaded", out_data, 108'h5);
        stall = 1'b1; in_data = 108'h6; out_ready = 1'b1;
        #1;
        chk("st_in_ready", in_ready, 0);
        tick(); tick(); tick();
        chk("st_out_held", out_data, 108'h5);
        chk("st_occ_held", occupancy, 1);
        chk("st_cnt_3", stall_cnt, 3);
        chk("sat_cnt_3", sat_stall_cnt, 3);
        tick(); tick();
        chk("st_cnt_5", stall_cnt, 5);
        chk("sat_cnt_saturated", sat_stall_cnt, 3);
        chk("sat_out_held", sat_out_data, 108'h5);
        stall = 1'b0; in_valid = 1'b0;
        tick();
        chk("st_consumed_valid", out_valid, 0);
        chk("st_consumed_occ", occupancy, 0);
        chk("st_data_persists", out_data, 108'h5);

        // Flush over stall
        out_ready = 1'b0; in_valid = 1'b1; in_data = 108'h11;
        tick();
        in_data = 108'h22;
        tick();
        chk("fl_pre_occ", occupancy, 2);
        flush = 1'b1; stall = 1'b1; in_data = 108'h33;
        tick();
        chk("fl_occ", occupancy, 0);
        chk("fl_out_data", out_data, 0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_cnt_1", flush_cnt, 1);
        chk("fl_stall_cnt_unchanged", stall_cnt, 5);
        stall = 1'b0; in_valid = 1'b0;
        tick();
        chk("fl_empty_cnt", flush_cnt, 1);
        chk("fl_empty_occ", occupancy, 0);
        flush = 1'b0;
        #1;
        chk("fl_in_ready", in_ready, 1);

        // SKID=0 variant
        s0_in_valid = 1'b1; s0_in_data = 108'h7; s0_out_ready = 1'b0;
        chk("s0_ready_empty", s0_in_ready, 1);
        tick();
        chk("s0_out_7", s0_out_data, 108'h7);
        chk("s0_valid_7", s0_out_valid, 1);
        s0_in_data = 108'h8;
        #1;
        chk("s0_ready_blocked", s0_in_ready, 0);
        s0_out_ready = 1'b1;
        #1;
        chk("s0_ready_same_cycle", s0_in_ready, 1);
        tick();
        chk("s0_out_8", s0_out_data, 108'h8);
        chk("s0_valid_8", s0_out_valid, 1);
        chk("s0_occ_8", s0_occupancy, 1);
        s0_in_valid = 1'b0;
        tick();
        chk("s0_drain_valid", s0_out_valid, 0);

        // Reset mid-transfer
        out_ready = 1'b0; in_valid = 1'b1; in_data = 108'h44;
        tick();
        chk("mr_loaded", out_data, 108'h44);
        rst = 1'b0; stall = 1'b1;
        tick();
        rst = 1'b1; stall = 1'b0; in_valid = 1'b0;
        chk("mr_occ", occupancy, 0);
        chk("mr_out_data", out_data, 0);
        chk("mr_stall_cnt", stall_cnt, 0);
        chk("mr_flush_cnt", flush_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
